// File: rtl/neuron_pkg.sv
// Shared constants, activation/accumulator types and the saturating narrow
// helper used by the neuron output path.
package neuron_pkg;

    localparam int ACC_W = 18;
    localparam int ACT_W = 8;
    localparam int LANES = 4;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACT_W-1:0] act_t;

    // Clamp a sign-extended value into the signed act_w-bit range; the
    // result stays 32 bits wide so callers can detect clipping by comparison.
    function automatic logic signed [31:0] sat_act(input logic signed [31:0] v,
                                                   input int                 act_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (act_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (act_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: arithmetic right shift (optionally rounded when
// ROUND_EN is defined) followed by saturation to a signed ACT_W activation.
module requant_sat
    import neuron_pkg::sat_act;
#(
    parameter int ACC_W = 18,
    parameter int ACT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic [ACC_W-1:0] in_data,
    output logic [ACT_W-1:0] act,
    output logic             clipped
);

    // One extra bit of headroom keeps the rounding add from wrapping.
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] shifted;
    logic signed [31:0]    wide;
    logic signed [31:0]    sat;

    assign ext = {in_data[ACC_W-1], in_data};

`ifdef ROUND_EN
    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
        assign shifted = (ext + HALF) >>> SHIFT;
    end else begin : g_trunc
        assign shifted = ext >>> SHIFT;
    end
`else
    assign shifted = ext >>> SHIFT;
`endif

    assign wide    = 32'(shifted);
    assign sat     = sat_act(wide, ACT_W);
    assign clipped = (sat != wide);
    assign act     = sat[ACT_W-1:0];

endmodule

// File: rtl/neuron_output_packer.sv
// Packs requantised neuron outputs into LANES-wide activation vectors with
// valid/ready on both sides. Optional rounding: define ROUND_EN.
module neuron_output_packer #(
    parameter int ACC_W = neuron_pkg::ACC_W,
    parameter int ACT_W = neuron_pkg::ACT_W,
    parameter int LANES = neuron_pkg::LANES,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_W-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACT_W-1:0] out_vec,
    output logic [LANES-1:0]       out_mask,
    output logic [7:0]             sat_count
);

    localparam int               CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]       lane_cnt;
    logic [LANES*ACT_W-1:0] pack_reg;
    logic [LANES*ACT_W-1:0] pack_next;
    logic [LANES-1:0]       mask_next;
    logic [ACT_W-1:0]       act;
    logic                   clipped;
    logic                   accept;
    logic                   complete;

    requant_sat #(
        .ACC_W (ACC_W),
        .ACT_W (ACT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .in_data (in_data),
        .act     (act),
        .clipped (clipped)
    );

    // A held output stalls every input word, not only a completing one.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (lane_cnt == LAST_LANE));

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        pack_next = pack_reg;
        mask_next = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) == lane_cnt) begin
                pack_next[i*ACT_W +: ACT_W] = act;
            end
            mask_next[i] = (CNT_W'(i) <= lane_cnt);
        end
    end

    // NOTE: the pack register is reset, not left as storage, because unfilled lanes must read 0.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            lane_cnt <= '0;
            pack_reg <= '0;
        end else if (complete) begin
            lane_cnt <= '0;
            pack_reg <= '0;
        end else if (accept) begin
            lane_cnt <= lane_cnt + 1'b1;
            pack_reg <= pack_next;
        end
    end

    // Completion wins over a simultaneous output handshake: reload with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_mask  <= '0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_vec   <= pack_next;
            out_mask  <= mask_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (accept && clipped && (sat_count != 8'hFF)) begin
            sat_count <= sat_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_neuron_output_packer.sv
// Randomised and directed bench for neuron_output_packer: one instance with
// SHIFT=0 and one with SHIFT=2 share stimulus and are checked against a model.
module tb_neuron_output_packer;

    localparam int ACC_W = 18;
    localparam int ACT_W = 8;
    localparam int LANES = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic [ACC_W-1:0]       in_data;
    logic                   in_last;
    logic                   out_ready;
    logic                   in_ready_a, in_ready_b;
    logic                   out_valid_a, out_valid_b;
    logic [LANES*ACT_W-1:0] out_vec_a, out_vec_b;
    logic [LANES-1:0]       out_mask_a, out_mask_b;
    logic [7:0]             sat_a, sat_b;

    always #5 clk = ~clk;

    neuron_output_packer #(.ACC_W(ACC_W), .ACT_W(ACT_W), .LANES(LANES), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_vec(out_vec_a), .out_mask(out_mask_a),
        .sat_count(sat_a)
    );

    neuron_output_packer #(.ACC_W(ACC_W), .ACT_W(ACT_W), .LANES(LANES), .SHIFT(2)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_vec(out_vec_b), .out_mask(out_mask_b),
        .sat_count(sat_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: lists of pending activations and a queue of vectors.
    typedef struct {
        logic [31:0] vec_a;
        logic [31:0] vec_b;
        logic [3:0]  mask;
    } exp_t;

    exp_t exp_q[$];
    int   lanes_a[$];
    int   lanes_b[$];
    int   sat_a_m = 0;
    int   sat_b_m = 0;

    function automatic int floor_div(input int t, input int d);
        int q;
        q = t / d;
        if ((t % d != 0) && (t < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_requant(input int v, input int sh, output bit clip);
        int d, t, q, hi, lo;
        d = 1 << sh;
        t = v;
`ifdef ROUND_EN
        if (sh > 0) t = v + d / 2;
`endif
        q    = floor_div(t, d);
        hi   = (1 << (ACT_W - 1)) - 1;
        lo   = -(1 << (ACT_W - 1));
        clip = 1'b0;
        if (q > hi) begin q = hi; clip = 1'b1; end
        else if (q < lo) begin q = lo; clip = 1'b1; end
        return q;
    endfunction

    task automatic model_accept(input logic [ACC_W-1:0] d, input bit last);
        int   v;
        bit   ca, cb;
        exp_t e;
        v = int'($signed(d));
        lanes_a.push_back(ref_requant(v, 0, ca));
        lanes_b.push_back(ref_requant(v, 2, cb));
        if (ca && sat_a_m < 255) sat_a_m++;
        if (cb && sat_b_m < 255) sat_b_m++;
        if (lanes_a.size() == LANES || last) begin
            e.vec_a = '0;
            e.vec_b = '0;
            e.mask  = '0;
            for (int i = 0; i < lanes_a.size(); i++) begin
                e.vec_a[i*ACT_W +: ACT_W] = 8'(lanes_a[i]);
                e.vec_b[i*ACT_W +: ACT_W] = 8'(lanes_b[i]);
                e.mask[i] = 1'b1;
            end
            exp_q.push_back(e);
            lanes_a.delete();
            lanes_b.delete();
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        lanes_a.delete();
        lanes_b.delete();
        sat_a_m = 0;
        sat_b_m = 0;
    endtask

    // One clock cycle: drive at negedge, compare, then account for any transfer.
    task automatic step(input bit v, input logic [ACC_W-1:0] d, input bit last,
                        input bit ordy, output bit acc);
        bit rdy_exp;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        #1;
        rdy_exp = !(exp_q.size() > 0 && !ordy);
        check("in_ready_a", 32'(in_ready_a), 32'(rdy_exp));
        check("in_ready_b", 32'(in_ready_b), 32'(rdy_exp));
        check("out_valid_a", 32'(out_valid_a), 32'(exp_q.size() > 0));
        check("out_valid_b", 32'(out_valid_b), 32'(exp_q.size() > 0));
        check("sat_count_a", 32'(sat_a), 32'(sat_a_m));
        check("sat_count_b", 32'(sat_b), 32'(sat_b_m));
        if (exp_q.size() > 0) begin
            check("out_vec_a", out_vec_a, exp_q[0].vec_a);
            check("out_vec_b", out_vec_b, exp_q[0].vec_b);
            check("out_mask", 32'(out_mask_a), 32'(exp_q[0].mask));
            if (ordy) void'(exp_q.pop_front());
        end
        acc = v && rdy_exp;
        if (acc) model_accept(d, last);
    endtask

    task automatic send(input logic [ACC_W-1:0] d, input bit last);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 32 && !acc; t++) step(1'b1, d, last, 1'b1, acc);
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, ordy, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_sat_count", 32'(sat_a), 32'd0);
        check("rst_out_vec", out_vec_a, 32'd0);
        check("rst_out_mask", 32'(out_mask_a), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit               acc;
        logic [ACC_W-1:0] d;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();

        // Full vector, SHIFT=0 on dut; the SHIFT=2 instance sees the same words.
        send(18'd49, 1'b0);
        send(18'h3FFF9, 1'b0);
        send(18'd509, 1'b0);
        send(18'd3, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("full_vec", out_vec_a, 32'h037F_F931);
        check("full_mask", 32'(out_mask_a), 32'hF);
        check("full_sat", 32'(sat_a), 32'd1);
        idle(1, 1'b1);

        // SHIFT=2 requantisation: 6, 509, -385.
        send(18'd6, 1'b0);
        send(18'd509, 1'b0);
        send(18'h3FE7F, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, acc);
`ifdef ROUND_EN
        check("shift2_vec", out_vec_b, 32'h00A0_7F02);
`else
        check("shift2_vec", out_vec_b, 32'h009F_7F01);
`endif
        check("shift2_mask", 32'(out_mask_b), 32'h7);
        idle(1, 1'b1);

        // Backpressure: full vector held while more words are offered.
        for (int k = 1; k <= 4; k++) send(18'(k), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 18'd99, 1'b0, 1'b0, acc);
        for (int k = 5; k <= 8; k++) send(18'(k), 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);

        // Partial flush, then the next word must land in lane 0.
        send(18'd10, 1'b0);
        send(18'd20, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("flush_vec", out_vec_a, 32'h0000_140A);
        check("flush_mask", 32'(out_mask_a), 32'h3);
        send(18'd5, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("lane0_vec", out_vec_a, 32'h0000_0005);
        idle(1, 1'b1);

        // Saturation counter sticks at 255.
        for (int k = 0; k < 300; k++) send(18'h1FFFF, 1'b0);
        idle(1, 1'b1);
        check("sat_sticky", 32'(sat_a), 32'd255);
        send(18'h20000, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("neg_clip_lane0", 32'(out_vec_a[7:0]), 32'h80);
        idle(1, 1'b1);

        // Reset with a pending output, and reset with a partial vector.
        send(18'd1, 1'b0);
        send(18'd2, 1'b1);
        idle(1, 1'b0);
        do_reset();
        send(18'd7, 1'b0);
        send(18'd8, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) send(18'(k + 40), 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("post_rst_vec", out_vec_a, 32'h2B2A_2928);
        check("post_rst_mask", 32'(out_mask_a), 32'hF);
        idle(1, 1'b1);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 3))
                0: d = 18'($urandom_range(0, 255) - 128);
                1: d = 18'($urandom);
                2: d = ($urandom_range(0, 1) != 0) ? 18'($urandom_range(500, 520))
                                                  : 18'(-int'($urandom_range(500, 520)));
                default: d = 18'($urandom_range(0, 700) - 350);
            endcase
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 3) != 0, acc);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
